drum_envelope: RTL and testbench

Amplitude-envelope stage between the noise-modulated sine source and the 8-bit GPIO DAC output. A trigger (switch or pad input) starts a linear attack followed by a pseudo-exponential decay, giving the tone a percussive "hit" shape. Samples are offset-binary (0x80 = silence) on both input and output.

---
 rtl/drum_envelope.sv | 109 ++++++++++
 tb/tb_drum_envelope.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/drum_envelope.sv
// rtl/drum_envelope.sv - percussive attack/decay envelope applied to an offset-binary sample stream
module drum_envelope #(
  parameter int PRESCALE    = 1550,
  parameter int ATTACK_STEP = 32,
  parameter int DECAY_SHIFT = 5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       trig_in,
  input  logic [7:0] sample_in,
  output logic [7:0] sample_out,
  output logic [7:0] amp_out,
  output logic       busy
);
  localparam int            CW   = $clog2(PRESCALE);
  localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);

  typedef enum logic [1:0] {IDLE, ATTACK, DECAY} state_t;

  state_t             r_state, w_state_next;
  logic [7:0]         r_amp, w_amp_next;
  logic [CW-1:0]      r_count;
  logic               r_s1, r_s2, r_s3;
  logic [7:0]         r_sample;
  logic               w_trig_edge, w_tick;
  logic [8:0]         w_sum;
  logic [7:0]         w_shr, w_dec;
  logic signed [16:0] w_s_ext, w_amp_ext, w_p;

  // Synchronizer comes out of reset "high" so a level held through reset is not taken as a new hit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_s1 <= 1'b1;
      r_s2 <= 1'b1;
      r_s3 <= 1'b1;
    end else begin
      r_s1 <= trig_in;
      r_s2 <= r_s1;
      r_s3 <= r_s2;
    end
  end

  assign w_trig_edge = r_s2 & ~r_s3;
  assign w_tick      = (r_count == LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset)       r_count <= '0;
    else if (w_tick) r_count <= '0;
    else             r_count <= r_count + CW'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_amp   <= 8'd0;
    end else begin
      r_state <= w_state_next;
      r_amp   <= w_amp_next;
    end
  end

  assign w_sum = {1'b0, r_amp} + 9'(ATTACK_STEP);
  assign w_shr = r_amp >> DECAY_SHIFT;
  assign w_dec = (w_shr == 8'd0) ? 8'd1 : w_shr;

  // A trigger edge wins over a coincident tick, leaving amp untouched on that cycle.
  always_comb begin
    w_state_next = r_state;
    w_amp_next   = r_amp;
    if (w_trig_edge) begin
      w_state_next = ATTACK;
    end else if (w_tick) begin
      case (r_state)
        IDLE: w_amp_next = 8'd0;
        ATTACK: begin
          if (w_sum >= 9'd255) begin
            w_amp_next   = 8'd255;
            w_state_next = DECAY;
          end else begin
            w_amp_next = w_sum[7:0];
          end
        end
        DECAY: begin
          if (r_amp > w_dec) begin
            w_amp_next = r_amp - w_dec;
          end else begin
            w_amp_next   = 8'd0;
            w_state_next = IDLE;
          end
        end
        default: w_state_next = IDLE;
      endcase
    end
  end

  // Offset-binary to two's complement is an MSB flip; the product floors via the arithmetic shift.
  assign w_s_ext   = {{10{~sample_in[7]}}, sample_in[6:0]};
  assign w_amp_ext = {9'd0, r_amp};
  assign w_p       = w_s_ext * w_amp_ext;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_sample <= 8'h80;
    else       r_sample <= 8'((w_p >>> 8) + 17'sd128);
  end

  assign sample_out = r_sample;
  assign amp_out    = r_amp;
  assign busy       = (r_state != IDLE);
endmodule

// File: tb/tb_drum_envelope.sv
// tb/tb_drum_envelope.sv - randomized bench with behavioural envelope model for drum_envelope
module tb_drum_envelope;
  localparam int PRESCALE    = 4;
  localparam int ATTACK_STEP = 64;
  localparam int DECAY_SHIFT = 2;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       trig_in = 1'b0;
  logic [7:0] sample_in = 8'hFF;
  logic [7:0] sample_out, amp_out;
  logic       busy;

  int checks = 0;
  int errors = 0;
  bit chk_en = 0;
  bit rnd = 0;

  drum_envelope #(
    .PRESCALE(PRESCALE), .ATTACK_STEP(ATTACK_STEP), .DECAY_SHIFT(DECAY_SHIFT)
  ) dut (
    .clk(clk), .reset(reset), .trig_in(trig_in), .sample_in(sample_in),
    .sample_out(sample_out), .amp_out(amp_out), .busy(busy)
  );

  initial forever #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: 128 + floor(s*amp/256), computed with plain integer arithmetic.
  function automatic int scale(input int samp, input int a);
    int p;
    int q;
    p = (samp - 128) * a;
    q = p / 256;
    if (p < 0 && q * 256 != p) q = q - 1;
    return 128 + q;
  endfunction

  int m_amp = 0;
  int m_sample = 128;
  int m_edges = 0;
  int m_d;
  bit m_busy = 0;
  bit m_attacking = 0;
  bit m_fire, m_tick;
  int hist [3] = '{1, 1, 1};

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_amp = 0; m_sample = 128; m_edges = 0;
      m_busy = 0; m_attacking = 0;
      hist = '{1, 1, 1};
    end else begin
      m_sample = scale(int'(sample_in), m_amp);
      m_edges++;
      m_tick = (m_edges % PRESCALE == 0);
      m_fire = (hist[1] == 1) && (hist[2] == 0);
      hist[2] = hist[1]; hist[1] = hist[0]; hist[0] = int'(trig_in);
      if (m_fire) begin
        m_busy = 1; m_attacking = 1;
      end else if (m_tick && m_busy) begin
        if (m_attacking) begin
          if (m_amp + ATTACK_STEP >= 255) begin m_amp = 255; m_attacking = 0; end
          else m_amp = m_amp + ATTACK_STEP;
        end else begin
          m_d = m_amp / (1 << DECAY_SHIFT);
          if (m_d == 0) m_d = 1;
          if (m_amp > m_d) m_amp = m_amp - m_d;
          else begin m_amp = 0; m_busy = 0; end
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("sample_out", int'(sample_out), m_sample);
      chk("amp_out", int'(amp_out), m_amp);
      chk("busy", int'(busy), int'(m_busy));
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(negedge clk);
      if (rnd) sample_in = 8'($urandom);
    end
  endtask

  task automatic wait_amp(input int exp, input string name);
    int last;
    int n;
    last = int'(amp_out);
    n = 0;
    do begin cyc(1); n++; end while (int'(amp_out) == last && n < 4 * PRESCALE);
    chk(name, int'(amp_out), exp);
  endtask

  int decay_seq [20] = '{192, 144, 108, 81, 61, 46, 35, 27, 21, 16, 12, 9, 7, 6, 5, 4, 3, 2, 1, 0};
  int n;

  initial begin
    chk("model_scale_00", scale(8'h00, 255), 8'h00);
    chk("model_scale_ff", scale(8'hFF, 255), 8'hFE);
    chk("model_scale_ff128", scale(8'hFF, 128), 8'hBF);

    #2 reset = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      chk("reset_sample", int'(sample_out), 8'h80);
      chk("reset_amp", int'(amp_out), 0);
      chk("reset_busy", int'(busy), 0);
    end
    chk_en = 1;
    #2 reset = 1'b0;
    rnd = 1;
    cyc(7);

    trig_in = 1'b1;
    cyc(1); chk("busy_edge1", int'(busy), 0);
    cyc(1); chk("busy_edge2", int'(busy), 0);
    cyc(1); chk("busy_edge3", int'(busy), 1);
    trig_in = 1'b0;
    wait_amp(64, "attack_64");
    wait_amp(128, "attack_128");
    rnd = 0;
    sample_in = 8'hFF; cyc(1); chk("scale_128_ff", int'(sample_out), 8'hBF);
    rnd = 1;
    wait_amp(192, "attack_192");
    wait_amp(255, "attack_255");
    rnd = 0;
    sample_in = 8'h00; cyc(1); chk("scale_255_00", int'(sample_out), 8'h00);
    sample_in = 8'hFF; cyc(1); chk("scale_255_ff", int'(sample_out), 8'hFE);
    sample_in = 8'h80; cyc(1); chk("scale_255_80", int'(sample_out), 8'h80);
    rnd = 1;
    foreach (decay_seq[i]) wait_amp(decay_seq[i], $sformatf("decay_%0d", i));
    chk("busy_fall", int'(busy), 0);
    cyc(10);
    chk("amp_hold0", int'(amp_out), 0);

    trig_in = 1'b1; cyc(3); trig_in = 1'b0;
    wait_amp(64, "re_64"); wait_amp(128, "re_128"); wait_amp(192, "re_192");
    wait_amp(255, "re_255"); wait_amp(192, "re_d192"); wait_amp(144, "re_d144");
    wait_amp(108, "re_d108");
    trig_in = 1'b1; cyc(3); trig_in = 1'b0;
    chk("retrig_hold108", int'(amp_out), 108);
    wait_amp(172, "retrig_172");
    wait_amp(236, "retrig_236");
    wait_amp(255, "retrig_255");
    wait_amp(192, "retrig_d192");
    cyc(1);
    trig_in = 1'b1;
    cyc(3);
    chk("coincide_hold", int'(amp_out), 192);
    chk("coincide_busy", int'(busy), 1);
    trig_in = 1'b0;
    cyc(4);
    chk("coincide_next", int'(amp_out), 255);

    n = 0;
    while (busy && n < 400) begin cyc(1); n++; end
    chk("decay_done", int'(busy), 0);
    trig_in = 1'b1; cyc(3); trig_in = 1'b0;
    wait_amp(64, "r6_64");
    wait_amp(128, "r6_128");
    #2 reset = 1'b1; trig_in = 1'b1;
    #1;
    chk("async_sample", int'(sample_out), 8'h80);
    chk("async_amp", int'(amp_out), 0);
    chk("async_busy", int'(busy), 0);
    cyc(3);
    #2 reset = 1'b0;
    cyc(20);
    chk("held_no_trig", int'(busy), 0);
    trig_in = 1'b0; cyc(2);
    trig_in = 1'b1; cyc(2);
    chk("toggle_edge2", int'(busy), 0);
    cyc(1);
    chk("toggle_edge3", int'(busy), 1);
    cyc(10);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
    $fatal(1);
  end
endmodule
